// File: rtl/ysyx_23060236_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060236_rd_arbiter_if
//
// One AXI-style read channel: address request plus read-data return.
// The IFU, the LSU and the downstream memory port each use one of these.
//
//   arvalid / arready : read-address handshake
//   ar[42:0]          : {araddr[31:0], arlen[7:0], arsize[2:0]}
//   rvalid  / rready  : read-data handshake
//   r[34:0]           : {rdata[31:0], rresp[1:0], rlast}
//
// Modports:
//   master : the side that issues addresses and consumes data
//   slave  : the side that accepts addresses and returns data
// ----------------------------------------------------------------------------
interface ysyx_23060236_rd_arbiter_if;
    logic        arvalid;
    logic        arready;
    logic [42:0] ar;
    logic        rvalid;
    logic        rready;
    logic [34:0] r;

    modport master (
        output arvalid, ar, rready,
        input  arready, rvalid, r
    );

    modport slave (
        input  arvalid, ar, rready,
        output arready, rvalid, r
    );
endinterface

// File: rtl/ysyx_23060236_rd_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060236_rd_arbiter
//
// Two-master read arbiter sharing one downstream read port between the IFU
// (m0) and the LSU (m1). One transaction is in flight at a time:
// IDLE grants, AR issues the latched address, R streams beats back to the
// granted master until rlast. The LSU normally wins, but after STARVE_MAX
// consecutive LSU grants while the IFU was waiting, the IFU is forced in.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   m0           : IFU read channel (slave side of the arbiter)
//   m1           : LSU read channel (slave side of the arbiter)
//   s            : downstream read channel (master side of the arbiter)
//   s_arid       : 0 when the IFU owns the transaction, 1 for the LSU
//   busy         : high whenever a transaction is in progress
//   err          : sticky flag, rlast did not line up with arlen+1
// ----------------------------------------------------------------------------
module ysyx_23060236_rd_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    ysyx_23060236_rd_arbiter_if.slave          m0,
    ysyx_23060236_rd_arbiter_if.slave          m1,
    ysyx_23060236_rd_arbiter_if.master         s,
    output logic [3:0]                         s_arid,
    output logic                               busy,
    output logic                               err
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;     // 0 = IFU, 1 = LSU
    logic [42:0]     ar_q, ar_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [7:0]      beat_q, beat_d;
    logic            err_q, err_d;

    logic            req_any;
    logic            starved;
    logic            pick_ifu;
    logic            in_idle;
    logic            in_r;
    logic            beat_fire;
    logic            rlast;
    logic [8:0]      beat_num;
    logic [8:0]      exp_beats;

    assign req_any  = m0.arvalid | m1.arvalid;
    assign starved  = (starve_q == SW'(STARVE_MAX));
    // IFU wins when it is the only requester, or when the LSU has starved it.
    assign pick_ifu = m0.arvalid & (~m1.arvalid | starved);

    // Every handshake output is forced low while reset is asserted, even
    // though the state flops only clear on the following edge.
    assign in_idle  = ~reset & (state_q == IDLE);
    assign in_r     = ~reset & (state_q == R);

    assign m0.arready = in_idle & pick_ifu;
    assign m1.arready = in_idle & m1.arvalid & ~pick_ifu;

    assign s.arvalid  = ~reset & (state_q == AR);
    assign s.ar       = ar_q;
    assign s_arid     = {3'b000, grant_q};

    assign s.rready   = in_r & (grant_q ? m1.rready : m0.rready);
    assign m0.rvalid  = in_r & ~grant_q & s.rvalid;
    assign m1.rvalid  = in_r &  grant_q & s.rvalid;
    assign m0.r       = s.r;
    assign m1.r       = s.r;

    assign busy       = ~reset & (state_q != IDLE);
    assign err        = err_q;

    assign beat_fire  = s.rvalid & s.rready;
    assign rlast      = s.r[0];
    // Nine bits so that arlen = 255 still has a reachable expected count.
    assign beat_num   = {1'b0, beat_q} + 9'd1;
    assign exp_beats  = {1'b0, ar_q[10:3]} + 9'd1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ar_d     = ar_q;
        starve_d = starve_q;
        beat_d   = beat_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = ~pick_ifu;
                    ar_d    = pick_ifu ? m0.ar : m1.ar;
                    beat_d  = 8'd0;
                    state_d = AR;
                    if (pick_ifu) begin
                        starve_d = '0;
                    end else if (m0.arvalid && !starved) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            AR: begin
                if (s.arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (beat_fire) begin
                    beat_d = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
                    if (rlast) begin
                        state_d = IDLE;
                        if (beat_num != exp_beats) begin
                            err_d = 1'b1;
                        end
                    end else if (beat_num == exp_beats) begin
                        // Burst should have ended here; keep draining until rlast.
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            ar_q     <= '0;
            starve_q <= '0;
            beat_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ar_q     <= ar_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060236_rd_arbiter
//
// Bench for the IFU/LSU read arbiter. Read beats are pushed to a scoreboard
// queue as the downstream side drives them; a monitor pops and compares each
// beat that reaches a master. Grant, hold and error behaviour are checked
// inline by each scenario task.
// ----------------------------------------------------------------------------
module tb_ysyx_23060236_rd_arbiter;

    typedef struct packed {
        logic        id;
        logic [34:0] r;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s_arid;
    logic       busy;
    logic       err;

    int   n_pass  = 0;
    int   n_total = 0;
    int   pulses0 = 0;
    int   pulses1 = 0;
    exp_t sb[$];

    ysyx_23060236_rd_arbiter_if m0_if ();
    ysyx_23060236_rd_arbiter_if m1_if ();
    ysyx_23060236_rd_arbiter_if s_if ();

    ysyx_23060236_rd_arbiter #(.STARVE_MAX(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .s_arid (s_arid),
        .busy   (busy),
        .err    (err)
    );

    // 10 ns clock; inputs change on the falling edge, checks follow by #1.
    always #5 clock = ~clock;

    // Scoreboard monitor: every beat delivered to a master is popped and
    // compared against what the downstream side was told to send.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (m0_if.rvalid && m0_if.rready) pulses0++;
        if (m1_if.rvalid && m1_if.rready) pulses1++;
        if (m0_if.rvalid || m1_if.rvalid) begin
            n_total++;
            if (m0_if.rvalid && m1_if.rvalid) begin
                $display("[TB] FAIL rvalid_exclusive: got both rvalid high, expected one");
            end else if (sb.size() == 0) begin
                $display("[TB] FAIL sb_underflow: got beat on m%0d, expected none", m1_if.rvalid);
            end else begin
                e = sb.pop_front();
                if ({m1_if.rvalid, (m1_if.rvalid ? m1_if.r : m0_if.r)} !== {e.id, e.r})
                    $display("[TB] FAIL beat_data: got m%0d %h, expected m%0d %h",
                             m1_if.rvalid, (m1_if.rvalid ? m1_if.r : m0_if.r), e.id, e.r);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [42:0] mk_ar(input logic [31:0] addr, input logic [7:0] len);
        return {addr, len, 3'd2};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        m0_if.arvalid  = 1'b0;
        m1_if.arvalid  = 1'b0;
        m0_if.ar       = '0;
        m1_if.ar       = '0;
        m0_if.rready   = 1'b1;
        m1_if.rready   = 1'b1;
        s_if.arready   = 1'b0;
        s_if.rvalid    = 1'b0;
        s_if.r         = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        pulses0 = 0;
        pulses1 = 0;
    endtask

    // Single requester, grant, then accept the address downstream.
    // Returns just after the edge that enters R.
    task automatic enter_r(input logic who, input logic [42:0] a);
        @(negedge clock);
        if (who) begin m1_if.arvalid = 1'b1; m1_if.ar = a; end
        else     begin m0_if.arvalid = 1'b1; m0_if.ar = a; end
        @(posedge clock);
        @(negedge clock);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        s_if.arready  = 1'b1;
        @(posedge clock);
        #1 s_if.arready = 1'b0;
    endtask

    // Downstream returns n beats; rlast is set on beat last_at (0 = never).
    task automatic drive_beats(input int n, input int last_at, input logic who, input logic [1:0] resp);
        logic [31:0] d;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            d           = $urandom;
            s_if.rvalid = 1'b1;
            s_if.r      = {d, resp, (i == last_at)};
            sb.push_back('{id: who, r: s_if.r});
            @(posedge clock);
        end
        #1 s_if.rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset         = 1'b1;
        m0_if.arvalid = 1'b1;
        m1_if.arvalid = 1'b1;
        m0_if.rready  = 1'b1;
        m1_if.rready  = 1'b1;
        s_if.arready  = 1'b0;
        s_if.rvalid   = 1'b0;
        s_if.r        = '0;
        m0_if.ar      = mk_ar(32'h1111_0000, 8'd0);
        m1_if.ar      = mk_ar(32'h2222_0000, 8'd0);
        #1;
        n_total++;
        if ({m0_if.arready, m1_if.arready} !== 2'b00)
            $display("[TB] FAIL reset_arready: got %b, expected 00", {m0_if.arready, m1_if.arready});
        else n_pass++;
        n_total++;
        if ({busy, s_if.arvalid, s_if.rready} !== 3'b000)
            $display("[TB] FAIL reset_outputs: got %b, expected 000", {busy, s_if.arvalid, s_if.rready});
        else n_pass++;
        @(posedge clock);
        @(negedge clock);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        #1;
        n_total++;
        if ({s_if.ar, s_arid, err} !== 48'd0)
            $display("[TB] FAIL reset_regs: got ar=%h id=%h err=%b, expected zeros", s_if.ar, s_arid, err);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_priority();
        logic [42:0] b;
        do_reset();
        b = mk_ar(32'hA000_0040, 8'd0);
        @(negedge clock);
        m0_if.arvalid = 1'b1;
        m1_if.arvalid = 1'b1;
        m0_if.ar      = mk_ar(32'h8000_0000, 8'd0);
        m1_if.ar      = b;
        #1;
        n_total++;
        if ({m0_if.arready, m1_if.arready} !== 2'b01)
            $display("[TB] FAIL prio_grant: got %b, expected 01", {m0_if.arready, m1_if.arready});
        else n_pass++;
        @(posedge clock);
        @(negedge clock);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        #1;
        n_total++;
        if ({s_if.arvalid, s_arid, busy} !== {1'b1, 4'd1, 1'b1})
            $display("[TB] FAIL prio_issue: got arvalid=%b id=%0d busy=%b, expected 1 1 1",
                     s_if.arvalid, s_arid, busy);
        else n_pass++;
        n_total++;
        if (s_if.ar !== b)
            $display("[TB] FAIL prio_payload: got %h, expected %h", s_if.ar, b);
        else n_pass++;
        s_if.arready = 1'b1;
        @(posedge clock);
        #1 s_if.arready = 1'b0;
        drive_beats(1, 1, 1'b1, 2'b00);
        @(negedge clock);
        #1;
        n_total++;
        if ({busy, err, pulses1} !== {1'b0, 1'b0, 32'd1})
            $display("[TB] FAIL prio_done: got busy=%b err=%b beats=%0d, expected 0 0 1", busy, err, pulses1);
        else n_pass++;
    endtask

    task automatic test_ifu_burst();
        do_reset();
        enter_r(1'b0, mk_ar(32'h8000_0100, 8'd3));
        n_total++;
        if ({busy, s_if.arvalid} !== 2'b10)
            $display("[TB] FAIL burst_in_r: got busy=%b arvalid=%b, expected 1 0", busy, s_if.arvalid);
        else n_pass++;
        // Nonzero rresp must pass through without raising err.
        drive_beats(4, 4, 1'b0, 2'b10);
        @(negedge clock);
        #1;
        n_total++;
        if (pulses0 != 4 || pulses1 != 0)
            $display("[TB] FAIL burst_pulses: got m0=%0d m1=%0d, expected 4 0", pulses0, pulses1);
        else n_pass++;
        n_total++;
        if ({busy, err} !== 2'b00)
            $display("[TB] FAIL burst_end: got busy=%b err=%b, expected 0 0", busy, err);
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic        who;
        logic [42:0] wa;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            who = (k % 5 == 4) ? 1'b0 : 1'b1;
            @(negedge clock);
            m0_if.arvalid = 1'b1;
            m1_if.arvalid = 1'b1;
            m0_if.ar      = mk_ar(32'h1000 + k, 8'd0);
            m1_if.ar      = mk_ar(32'h2000 + k, 8'd0);
            wa            = who ? m1_if.ar : m0_if.ar;
            #1;
            n_total++;
            if ({m0_if.arready, m1_if.arready} !== {~who, who})
                $display("[TB] FAIL starve_grant%0d: got %b, expected %b",
                         k, {m0_if.arready, m1_if.arready}, {~who, who});
            else n_pass++;
            @(posedge clock);
            @(negedge clock);
            #1;
            n_total++;
            if ({s_arid, s_if.ar, m0_if.arready, m1_if.arready} !== {3'b000, who, wa, 2'b00})
                $display("[TB] FAIL starve_hold%0d: got id=%0d ar=%h rdy=%b, expected id=%0d ar=%h rdy=00",
                         k, s_arid, s_if.ar, {m0_if.arready, m1_if.arready}, who, wa);
            else n_pass++;
            s_if.arready = 1'b1;
            @(posedge clock);
            #1 s_if.arready = 1'b0;
            drive_beats(1, 1, who, 2'b00);
        end
        @(negedge clock);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        #1;
        n_total++;
        if (err !== 1'b0)
            $display("[TB] FAIL starve_err: got %b, expected 0", err);
        else n_pass++;
    endtask

    task automatic test_len_err();
        do_reset();
        enter_r(1'b0, mk_ar(32'h3000_0000, 8'd1));
        drive_beats(1, 1, 1'b0, 2'b00);
        @(negedge clock);
        #1;
        n_total++;
        if ({err, busy} !== 2'b10)
            $display("[TB] FAIL early_last: got err=%b busy=%b, expected 1 0", err, busy);
        else n_pass++;

        do_reset();
        #1;
        n_total++;
        if (err !== 1'b0)
            $display("[TB] FAIL err_cleared: got %b, expected 0", err);
        else n_pass++;
        enter_r(1'b0, mk_ar(32'h3000_0100, 8'd0));
        drive_beats(1, 0, 1'b0, 2'b00);
        @(negedge clock);
        #1;
        n_total++;
        if ({err, busy} !== 2'b11)
            $display("[TB] FAIL missing_last: got err=%b busy=%b, expected 1 1", err, busy);
        else n_pass++;
        drive_beats(1, 1, 1'b0, 2'b01);
        @(negedge clock);
        #1;
        n_total++;
        if (pulses0 != 2 || busy !== 1'b0 || err !== 1'b1)
            $display("[TB] FAIL late_last: got beats=%0d busy=%b err=%b, expected 2 0 1", pulses0, busy, err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // Four LSU wins while the IFU waits push starve_cnt to its limit;
        // the fourth is a 4-beat burst that gets reset partway through.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            m0_if.arvalid = 1'b1;
            m1_if.arvalid = 1'b1;
            m0_if.ar      = mk_ar(32'h4000, 8'd0);
            m1_if.ar      = mk_ar(32'h5000 + k, (k == 3) ? 8'd3 : 8'd0);
            @(posedge clock);
            @(negedge clock);
            s_if.arready = 1'b1;
            @(posedge clock);
            #1 s_if.arready = 1'b0;
            if (k < 3) drive_beats(1, 1, 1'b1, 2'b00);
            else       drive_beats(1, 0, 1'b1, 2'b00);
        end
        @(negedge clock);
        reset         = 1'b1;
        s_if.rvalid   = 1'b1;
        s_if.r        = {32'hDEAD_BEEF, 2'b00, 1'b0};
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        #1;
        n_total++;
        if ({s_if.rready, m1_if.rvalid, busy} !== 3'b000)
            $display("[TB] FAIL midrst_during: got rready=%b rvalid=%b busy=%b, expected 000",
                     s_if.rready, m1_if.rvalid, busy);
        else n_pass++;
        @(posedge clock);
        @(negedge clock);
        reset       = 1'b0;
        s_if.rvalid = 1'b0;
        #1;
        n_total++;
        if ({busy, s_if.rready, err, s_if.arvalid} !== 4'b0000)
            $display("[TB] FAIL midrst_after: got busy=%b rready=%b err=%b arvalid=%b, expected 0000",
                     busy, s_if.rready, err, s_if.arvalid);
        else n_pass++;
        m0_if.arvalid = 1'b1;
        m1_if.arvalid = 1'b1;
        #1;
        n_total++;
        if ({m0_if.arready, m1_if.arready} !== 2'b01)
            $display("[TB] FAIL midrst_starve: got %b, expected 01", {m0_if.arready, m1_if.arready});
        else n_pass++;
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
    endtask

    task automatic test_ar_stall();
        logic [42:0] a;
        logic [63:0] rnd;
        do_reset();
        a = mk_ar(32'h8000_0200, 8'd0);
        @(negedge clock);
        m0_if.arvalid = 1'b1;
        m0_if.ar      = a;
        @(posedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            rnd           = {$urandom, $urandom};
            m0_if.ar      = rnd[42:0] ^ 43'h1;
            rnd           = {$urandom, $urandom};
            m1_if.ar      = rnd[42:0];
            m1_if.arvalid = 1'b1;
            #1;
            n_total++;
            if ({s_if.ar, s_if.arvalid, m0_if.arready, m1_if.arready} !== {a, 3'b100})
                $display("[TB] FAIL stall%0d: got ar=%h v=%b rdy=%b, expected ar=%h v=1 rdy=00",
                         k, s_if.ar, s_if.arvalid, {m0_if.arready, m1_if.arready}, a);
            else n_pass++;
        end
        @(negedge clock);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        s_if.arready  = 1'b1;
        @(posedge clock);
        #1 s_if.arready = 1'b0;
        drive_beats(1, 1, 1'b0, 2'b00);
        @(negedge clock);
        #1;
        n_total++;
        if ({busy, err, pulses0} !== {1'b0, 1'b0, 32'd1})
            $display("[TB] FAIL stall_done: got busy=%b err=%b beats=%0d, expected 0 0 1", busy, err, pulses0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_ifu_burst();
        test_starvation();
        test_len_err();
        test_reset_mid_burst();
        test_ar_stall();
        n_total++;
        if (sb.size() != 0)
            $display("[TB] FAIL sb_leftover: got %0d pending beats, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_rd_arbiter.md
YSYX_23060236_RD_ARBITER -- requirements
Module: ysyx_23060236_rd_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive LSU grants, while IFU waits, after which IFU is forced to win.
REQ-002 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port m0_arvalid  in  1  IFU read-address valid.
REQ-005 SHALL have port m0_arready  out  1  IFU read-address accepted.
REQ-006 SHALL have port m0_ar  in  43  IFU payload {araddr[31:0], arlen[7:0], arsize[2:0]}.
REQ-007 SHALL have port m0_rvalid  out  1  IFU read-data valid.
REQ-008 SHALL have port m0_rready  in  1  IFU read-data ready.
REQ-009 SHALL have ports m1_arvalid, m1_arready, m1_ar, m1_rvalid, m1_rready, identical to the m0 ports, for the LSU.
REQ-010 SHALL have port s_arvalid  out  1  downstream read-address valid.
REQ-011 SHALL have port s_arready  in  1  downstream read-address ready.
REQ-012 SHALL have port s_ar  out  43  latched payload of the granted master.
REQ-013 SHALL have port s_arid  out  4  4'd0 when IFU is granted, 4'd1 when LSU is granted.
REQ-014 SHALL have port s_rvalid  in  1  downstream read-data valid.
REQ-015 SHALL have port s_rready  out  1  downstream read-data ready.
REQ-016 SHALL have port s_r  in  35  {rdata[31:0], rresp[1:0], rlast}.
REQ-017 SHALL have port m_r  out  35  s_r broadcast unchanged to both masters.
REQ-018 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-019 SHALL have port err  out  1  sticky burst-length mismatch flag.

Function
REQ-020 SHALL implement the states IDLE, AR and R.
REQ-021 SHALL, in IDLE with at least one arvalid high, grant in the same cycle: LSU wins unless starve_cnt equals STARVE_MAX, in which case IFU wins.
REQ-022 SHALL, on a grant, assert the winner's arready combinationally for that cycle only, latch its payload into s_ar and the winner id, clear the beat counter, and go to AR next cycle.
REQ-023 SHALL hold both arready outputs at 0 in the AR and R states.
REQ-024 SHALL, in AR, drive s_arvalid=1 with s_ar and s_arid stable, and on s_arready go to R; the address is issued one cycle after the grant.
REQ-025 SHALL, in R, set s_rready equal to the granted master's rready, drive only the granted master's rvalid from s_rvalid, and hold the other rvalid at 0.
REQ-026 SHALL count each R-state handshake as a beat, in an 8-bit counter that saturates.
REQ-027 SHALL, on a beat with rlast=1, return to IDLE next cycle, so a new grant is possible in the cycle after the last beat.
REQ-028 SHALL set err if rlast arrives on a beat number other than arlen+1.
REQ-029 SHALL set err if beat arlen+1 completes without rlast, and SHALL then remain in R until rlast.
REQ-030 SHALL pass rresp through unchanged and SHALL NOT treat a nonzero rresp as an error.
REQ-031 SHALL increment starve_cnt, saturating at STARVE_MAX, when LSU is granted while m0_arvalid=1.
REQ-032 SHALL clear starve_cnt when IFU is granted, and SHALL hold it otherwise.
REQ-033 SHALL NOT change the grant or payload from the moment of grant until return to IDLE, regardless of changes on any arvalid.

Reset
REQ-034 SHALL, on reset (checked every cycle, including mid-burst), go to IDLE and clear starve_cnt, the beat counter, err, s_ar and s_arid.
REQ-035 SHALL hold s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid and busy at 0 during reset.
REQ-036 SHALL NOT track outstanding downstream transactions across reset.

Verification
REQ-037 SHALL cover: both arvalid high in IDLE with starve_cnt=0 -> m1_arready=1 the same cycle, s_arid=1, s_arvalid=1 the next cycle.
REQ-038 SHALL cover: IFU burst with arlen=3 and rlast on beat 4 -> 4 m0_rvalid pulses, m1_rvalid=0 throughout, err=0, busy falls after beat 4.
REQ-039 SHALL cover: both masters requesting continuously, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IFU, repeating.
REQ-040 SHALL cover: arlen=1 with rlast on beat 1 -> err=1, back to IDLE; arlen=0 with rlast on beat 2 -> err=1, 2 beats delivered.
REQ-041 SHALL cover: reset asserted during beat 2 of 4 -> next cycle state IDLE, busy=0, s_rready=0, err=0, starve_cnt=0.
REQ-042 SHALL cover: s_arready held low for 5 cycles in AR with m0_ar changing -> s_ar stays at the latched value, both arready stay 0.
